// File: rtl/multiply_divide_unit_if.sv
// -----------------------------------------------------------------------------
// multiply_divide_unit_if
//
// Purpose: groups the execute-stage signals exchanged between the pipeline and
// the multiply/divide unit.
//
// Signals:
//   Req        pipeline -> MDU  exception/interrupt taken; E instruction flushed
//   MDUOpE     pipeline -> MDU  4-bit op code of the instruction in E
//   SrcAE      pipeline -> MDU  forwarded rs value
//   SrcBE      pipeline -> MDU  forwarded rt value
//   ReadHiE    pipeline -> MDU  1 selects HI, 0 selects LO on MDUOutE
//   StartMDUE  MDU -> pipeline  a multi-cycle op is launching this cycle
//   MDUBusyE   MDU -> pipeline  a multi-cycle op is in flight
//   MDUOutE    MDU -> pipeline  HI or LO, chosen by ReadHiE
//
// Handshake: there is no valid/ready pair. StartMDUE is a combinational
// "launch" indication and MDUBusyE a registered "in flight" indication; the
// hazard controller stalls MDU-class instructions in D on StartMDUE||MDUBusyE.
// The unit has no backpressure input.
// -----------------------------------------------------------------------------
interface multiply_divide_unit_if;
    logic        Req;
    logic [3:0]  MDUOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        ReadHiE;
    logic        StartMDUE;
    logic        MDUBusyE;
    logic [31:0] MDUOutE;

    modport master (
        output Req, MDUOpE, SrcAE, SrcBE, ReadHiE,
        input  StartMDUE, MDUBusyE, MDUOutE
    );

    modport slave (
        input  Req, MDUOpE, SrcAE, SrcBE, ReadHiE,
        output StartMDUE, MDUBusyE, MDUOutE
    );
endinterface

// File: rtl/multiply_divide_unit.sv
// -----------------------------------------------------------------------------
// multiply_divide_unit
//
// Purpose: execute-stage multiply/divide unit of the five-stage MIPS pipeline.
// Owns HI/LO, runs multi-cycle mult/multu (MULT_CYCLES) and div/divu
// (DIV_CYCLES), performs single-cycle mthi/mtlo and drives HI or LO out for
// mfhi/mflo.
//
// Ports:
//   clk          pipeline clock
//   resetn       synchronous, active-low reset
//   mdu          multiply_divide_unit_if.slave (Req, MDUOpE, SrcAE, SrcBE,
//                ReadHiE in; StartMDUE, MDUBusyE, MDUOutE out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = BUSY)
//
// Configuration macro: MDU_MADD_EN
//   defined   -> ops 7..10 (madd, maddu, msub, msubu) accumulate into {HI,LO}
//                using MULT_CYCLES
//   undefined -> ops 7..10 decode as no-op
// -----------------------------------------------------------------------------
module multiply_divide_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                         clk,
    input  logic                         resetn,
    multiply_divide_unit_if.slave        mdu,
    output logic                         o_dbg_state
);

    localparam logic [3:0] LP_MULT_CNT = MULT_CYCLES[3:0];
    localparam logic [3:0] LP_DIV_CNT  = DIV_CYCLES[3:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic        r_pwr;     // pending result is committed at completion

    // ---------------- decode ----------------
    logic w_is_mul, w_is_div, w_is_acc, w_acc_sub, w_signed, w_mthi, w_mtlo;

    always_comb begin
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_is_acc  = 1'b0;
        w_acc_sub = 1'b0;
        w_signed  = 1'b0;
        w_mthi    = 1'b0;
        w_mtlo    = 1'b0;
        case (mdu.MDUOpE)
            4'd1: begin w_is_mul = 1'b1; w_signed = 1'b1; end
            4'd2: begin w_is_mul = 1'b1; end
            4'd3: begin w_is_div = 1'b1; w_signed = 1'b1; end
            4'd4: begin w_is_div = 1'b1; end
            4'd5: begin w_mthi = 1'b1; end
            4'd6: begin w_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
            4'd7:  begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_signed = 1'b1; end
            4'd8:  begin w_is_mul = 1'b1; w_is_acc = 1'b1; end
            4'd9:  begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_acc_sub = 1'b1; w_signed = 1'b1; end
            4'd10: begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_acc_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic w_launch;
    logic w_done;
    assign w_launch = (w_is_mul | w_is_div) & ~mdu.Req;
    assign w_done   = (r_state == ST_BUSY) && (r_cnt == 4'd1);

    // ---------------- multiply / accumulate ----------------
    // One 64x64 multiplier serves both signednesses: operands are sign- or
    // zero-extended first and the low 64 bits of the product are exact.
    logic [63:0] w_a_ext, w_b_ext, w_prod, w_acc_base, w_mul_res;

    assign w_a_ext    = w_signed ? {{32{mdu.SrcAE[31]}}, mdu.SrcAE} : {32'd0, mdu.SrcAE};
    assign w_b_ext    = w_signed ? {{32{mdu.SrcBE[31]}}, mdu.SrcBE} : {32'd0, mdu.SrcBE};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_acc_base = {r_hi, r_lo};
    assign w_mul_res  = !w_is_acc ? w_prod :
                        (w_acc_sub ? (w_acc_base - w_prod) : (w_acc_base + w_prod));

    // ---------------- divide ----------------
    // A zero divisor and the 0x80000000 / -1 overflow both divide by 1
    // instead. For the overflow that yields exactly the required answer
    // (quotient 0x80000000, remainder 0); for a zero divisor the result is
    // discarded anyway.
    logic               w_div0, w_ovf;
    logic [31:0]        w_b_safe;
    logic signed [31:0] w_q_s, w_r_s;
    logic [31:0]        w_q_u, w_r_u, w_div_hi, w_div_lo;

    assign w_div0   = (mdu.SrcBE == 32'd0);
    assign w_ovf    = w_signed && (mdu.SrcAE == 32'h8000_0000) && (mdu.SrcBE == 32'hFFFF_FFFF);
    assign w_b_safe = (w_div0 || w_ovf) ? 32'd1 : mdu.SrcBE;
    assign w_q_s    = $signed(mdu.SrcAE) / $signed(w_b_safe);
    assign w_r_s    = $signed(mdu.SrcAE) % $signed(w_b_safe);
    assign w_q_u    = mdu.SrcAE / w_b_safe;
    assign w_r_u    = mdu.SrcAE % w_b_safe;
    assign w_div_lo = w_signed ? $unsigned(w_q_s) : w_q_u;
    assign w_div_hi = w_signed ? $unsigned(w_r_s) : w_r_u;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pwr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A launch while busy is ignored; the counter just keeps running.
            if ((r_state == ST_IDLE) && w_launch) begin
                r_cnt <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
                r_pwr <= !(w_is_div && w_div0);
                if (w_is_div) begin
                    r_phi <= w_div_hi;
                    r_plo <= w_div_lo;
                end else begin
                    r_phi <= w_mul_res[63:32];
                    r_plo <= w_mul_res[31:0];
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_mthi && !mdu.Req) r_hi <= mdu.SrcAE;
            if (w_mtlo && !mdu.Req) r_lo <= mdu.SrcAE;
            // Completion of an in-flight op is independent of Req: that op
            // belongs to an older, committed instruction.
            if (w_done && r_pwr) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == 4'd1) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mdu.StartMDUE = w_launch;
        mdu.MDUBusyE  = (r_state == ST_BUSY);
        mdu.MDUOutE   = mdu.ReadHiE ? r_hi : r_lo;
        o_dbg_state   = r_state;
    end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It owns the HI/LO registers and runs multi-cycle mult/multu (5 cycles) and div/divu (10 cycles). It performs single-cycle mthi/mtlo writes and returns HI or LO for mfhi/mflo. It is the direct producer of the `StartMDUE`/`MDUBusyE` pair that the hazard controller consumes to stall MDU-class instructions in D.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-class when enabled)
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  synchronous, active-low reset
- Req  in  1  exception/interrupt taken this cycle; instruction in E is being flushed
- MDUOpE  in  4  op in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 treated as none
- SrcAE  in  32  forwarded rs value
- SrcBE  in  32  forwarded rt value
- ReadHiE  in  1  1 = output HI, 0 = output LO
- StartMDUE  out  1  combinational; valid multi-cycle op in E and !Req
- MDUBusyE  out  1  registered; operation in flight
- MDUOutE  out  32  combinational; ReadHiE ? HI : LO

## Operation
- State: HI, LO (32 b each), cnt (4 b), pending result regs pHI/pLO.
- IDLE (cnt==0): on a StartMDUE edge, compute the result from SrcAE/SrcBE into pHI/pLO and load cnt = MULT_CYCLES or DIV_CYCLES.
- BUSY (cnt!=0): decrement each edge. On the edge where cnt goes 1→0, copy pHI→HI and pLO→LO.
- mult: signed 64-b product. multu: unsigned. {HI,LO} = product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned.
- 0x80000000 / 0xFFFFFFFF (div) → LO=0x80000000, HI=0.
- Divisor 0: cnt is still loaded (busy for DIV_CYCLES). HI/LO are left unchanged at completion.
- madd/maddu/msub/msubu: {HI,LO} ± product. The accumulate base is the HI/LO value at the start edge.
- mthi/mtlo (op 5/6), !Req: HI/LO ← SrcAE at the same edge. The op is not busy and does not assert StartMDUE.
- Req asserted: no start, no mthi/mtlo write. An operation already in flight is unaffected and completes normally, because it was started by an older, committed instruction.
- Start while busy is illegal; the hazard controller guarantees it never occurs. If it does occur, the start is ignored.
- Reset: HI=0, LO=0, cnt=0, pHI=pLO=0, MDUBusyE=0. Any in-flight result is discarded.
- Outputs at reset: MDUBusyE=0, MDUOutE=0. StartMDUE follows its inputs.

## Timing
- Start edge T: MDUBusyE=1 during cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO are visible on MDUOutE from cycle T+N+1, when MDUBusyE=0.
- The hazard controller stalls on StartMDUE||MDUBusyE. An mfhi entering E therefore always reads the completed value.
- mthi at edge T is visible on MDUOutE in cycle T+1.
- No handshake beyond start/busy. The unit has no backpressure input.

## Configuration
- MDU_MADD_EN defined: ops 7–10 decode as multi-cycle accumulate ops using MULT_CYCLES.
- MDU_MADD_EN undefined: ops 7–10 decode as none. They produce no start, no busy and no HI/LO change.

## Test plan
- Signed multiply: mult 0xFFFFFFFE × 0x00000003 → busy for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu of the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: div −7 / 2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Overflow case: 0x80000000 / −1 → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22; divu 5 / 0 → busy for 10 cycles; HI=0x11 and LO=0x22 afterwards.
- Flush and accumulate:
  - mult start with Req=1 → StartMDUE=0, MDUBusyE stays 0, HI/LO unchanged.
  - mthi 0xABCD with Req=1 → HI unchanged.
  - With MDU_MADD_EN, HI=0, LO=10, then madd 3×4 → LO=22.
  - Without MDU_MADD_EN, the same madd → LO=10 and no busy.
- Reset mid-operation: start div, deassert resetn at busy cycle 4 → MDUBusyE=0, HI=LO=0 next cycle, and no later write.
- mthi/mtlo and read path: mthi 0x12345678 then mtlo 0x9 on consecutive cycles → MDUOutE=0x12345678 with ReadHiE=1 and 0x9 with ReadHiE=0, one cycle after each write.
